// File: rtl/alu_out_stage.sv
// ALU output stage: result select, flag derivation and a 2-entry skid buffer with valid/ready.
// Optional ALU_OVF_FLAG_EN: store the add/sub overflow per entry and drive out_ovf from it.
module alu_out_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] logic_result,
  input  logic [WIDTH-1:0] arith_result,
  input  logic             arith_ovf,
  input  logic [WIDTH-1:0] shift_result,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

`ifdef ALU_OVF_FLAG_EN
  localparam int unsigned EW = WIDTH + 1;
`else
  localparam int unsigned EW = WIDTH;
`endif

  state_e          state_q, state_d;
  logic            in_ready_q;
  logic [EW-1:0]   head_q, head_d;
  logic [EW-1:0]   skid_q, skid_d;
  logic [WIDTH-1:0] sel_res;
  logic [EW-1:0]   new_entry;
  logic            accept, pop;

  // Low opcode bits pick the operation inside a unit; only the group matters here.
  logic unused_aluop_lo;
  assign unused_aluop_lo = ^aluOp[1:0];

  always_comb begin
    sel_res = '0;
    unique case (aluOp[3:2])
      2'b00: sel_res = arith_result;
      2'b01: sel_res = logic_result;
      2'b10: sel_res = shift_result;
      2'b11: sel_res = {{(WIDTH-1){1'b0}}, arith_result[WIDTH-1] ^ arith_ovf};
    endcase
  end

`ifdef ALU_OVF_FLAG_EN
  assign new_entry = {(aluOp[3:2] == 2'b00) & arith_ovf, sel_res};
  assign out_ovf   = head_q[WIDTH];
`else
  assign new_entry = sel_res;
  assign out_ovf   = 1'b0;
`endif

  assign accept = in_valid & in_ready_q;
  assign pop    = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = new_entry;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = FULL;
          skid_d  = new_entry;
        end else if (accept && pop) begin
          head_d  = new_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a flop of the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = head_q[WIDTH-1:0];
  assign out_zero   = (head_q[WIDTH-1:0] == '0);
  assign out_neg    = head_q[WIDTH-1];

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: queue-based reference model plus directed vectors.
module tb_alu_out_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  aluOp;
  logic [31:0] logic_result, arith_result, shift_result;
  logic        arith_ovf;
  logic        in_valid, in_ready;
  logic [31:0] out_result;
  logic        out_zero, out_neg, out_ovf, out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  typedef struct {
    logic [31:0] r;
    logic        o;
  } ent_t;
  ent_t q[$];

  alu_out_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .aluOp(aluOp),
    .logic_result(logic_result), .arith_result(arith_result), .arith_ovf(arith_ovf),
    .shift_result(shift_result), .in_valid(in_valid), .in_ready(in_ready),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

`ifdef ALU_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  function automatic ent_t model_sel();
    ent_t e;
    int grp = int'(aluOp) / 4;
    e.o = 1'b0;
    if (grp == 0) begin
      e.r = arith_result;
      e.o = OVF_EN && arith_ovf;
    end else if (grp == 1) e.r = logic_result;
    else if (grp == 2) e.r = shift_result;
    else begin
      // Signed less-than: true sign of the difference is the raw sign corrected by overflow.
      e.r = (arith_result[31] != arith_ovf) ? 32'd1 : 32'd0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      started = 1'b1;
    end else if (started) begin
      bit do_pop, do_acc;
      do_pop = (q.size() != 0) && out_ready;
      do_acc = in_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(model_sel());
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL model_valid: got %b expected %b", out_valid, q.size() != 0);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL model_in_ready: got %b expected %b", in_ready, q.size() < 2);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_result !== q[0].r || out_zero !== (q[0].r == 32'd0) ||
            out_neg !== q[0].r[31] || out_ovf !== q[0].o) begin
          errors++;
          $display("FAIL model_head: got r=%h z=%b n=%b o=%b expected r=%h z=%b n=%b o=%b",
                   out_result, out_zero, out_neg, out_ovf,
                   q[0].r, q[0].r == 32'd0, q[0].r[31], q[0].o);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] op, input logic [31:0] lr, input logic [31:0] ar,
                     input logic ao, input logic [31:0] sr);
    aluOp = op; logic_result = lr; arith_result = ar; arith_ovf = ao; shift_result = sr;
    in_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aluOp = '0;
    logic_result = '0; arith_result = '0; arith_ovf = 1'b0; shift_result = '0;
    repeat (2) cyc();
    reset = 1'b0;

    // Fill to FULL, then reset mid-transfer
    put(4'b0000, 32'h0, 32'h11, 1'b0, 32'h0); cyc();
    put(4'b0000, 32'h0, 32'h22, 1'b0, 32'h0); cyc();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_result", out_result, 32'h0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    cyc();

    // Logical result, one-cycle latency
    out_ready = 1'b1;
    put(4'b0100, 32'h0000_00F0, 32'h0, 1'b0, 32'h0); cyc(); in_valid = 1'b0;
    chk("logic_result", out_result, 32'h0000_00F0);
    chk("logic_zero", {31'd0, out_zero}, 32'd0);
    chk("logic_neg", {31'd0, out_neg}, 32'd0);
    chk("logic_valid", {31'd0, out_valid}, 32'd1);
    cyc();

    // Arith with overflow
    put(4'b0010, 32'h0, 32'h8000_0000, 1'b1, 32'h0); cyc(); in_valid = 1'b0;
    chk("arith_result", out_result, 32'h8000_0000);
    chk("arith_neg", {31'd0, out_neg}, 32'd1);
    chk("arith_ovf", {31'd0, out_ovf}, OVF_EN ? 32'd1 : 32'd0);
    cyc();

    // SLT corrected by overflow
    put(4'b1100, 32'h0, 32'h7FFF_FFFF, 1'b1, 32'h0); cyc(); in_valid = 1'b0;
    chk("slt_result", out_result, 32'h1);
    chk("slt_ovf", {31'd0, out_ovf}, 32'd0);
    cyc();

    // SLT false -> zero flag
    put(4'b1111, 32'h0, 32'h0000_0005, 1'b0, 32'h0); cyc(); in_valid = 1'b0;
    chk("slt0_result", out_result, 32'h0);
    chk("slt0_zero", {31'd0, out_zero}, 32'd1);
    cyc();

    // Shift with stray ovf must not set out_ovf
    put(4'b1001, 32'h0, 32'h0, 1'b1, 32'hF000_0000); cyc(); in_valid = 1'b0;
    chk("shift_result", out_result, 32'hF000_0000);
    chk("shift_neg", {31'd0, out_neg}, 32'd1);
    chk("shift_ovf", {31'd0, out_ovf}, 32'd0);
    cyc();

    // Backpressure
    out_ready = 1'b0;
    put(4'b0000, 32'h0, 32'd1, 1'b0, 32'h0); cyc();
    put(4'b0000, 32'h0, 32'd2, 1'b0, 32'h0); cyc();
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head", out_result, 32'd1);
    put(4'b0000, 32'h0, 32'd3, 1'b0, 32'h0); cyc();
    chk("bp_hold", out_result, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_second", out_result, 32'd2);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming
    for (int i = 0; i < 10; i++) begin
      put(4'b0100, 32'(i), 32'h0, 1'b0, 32'h0); cyc();
      chk("stream_result", out_result, 32'(i));
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
